// File: rtl/torpedo_launch_scheduler.sv
// Central fire scheduler: debounced-edge requests, per-frame cooldown, round-robin slot grant, flight lifetime tracking.
// Optional build macro TORPEDO_AUTOFIRE_EN adds held-button autofire on frame ticks.
module torpedo_launch_scheduler #(
  parameter int T_NUM           = 4,
  parameter int LIFE_FRAMES     = 60,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_pulse,
  input  logic             fire,
  input  logic             enable,
  input  logic [T_NUM-1:0] hit,
  output logic [T_NUM-1:0] launch,
  output logic [T_NUM-1:0] active,
  output logic             all_busy,
  output logic [15:0]      shots_fired
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int LW = $clog2(LIFE_FRAMES + 1);
  localparam int PW = $clog2(T_NUM);

  logic             fire_d_r;
  logic [CW-1:0]    cooldown_r;
  logic [PW-1:0]    rr_ptr_r;
  logic [LW-1:0]    life_r [T_NUM];
  logic [T_NUM-1:0] active_r;
  logic [T_NUM-1:0] launch_r;
  logic             all_busy_r;
  logic [15:0]      shots_r;

  logic             req_s;
  logic             grant_s;
  logic [PW-1:0]    sel_s;
  logic             sel_valid_s;
  logic [T_NUM-1:0] active_nxt_s;
  logic [LW-1:0]    life_nxt_s [T_NUM];
  logic [CW-1:0]    cooldown_nxt_s;
  logic [T_NUM-1:0] launch_nxt_s;
  logic [PW-1:0]    rr_ptr_nxt_s;
  logic [15:0]      shots_nxt_s;

  // Request detection and grant qualification on pre-update state
  always_comb begin
`ifdef TORPEDO_AUTOFIRE_EN
    req_s = (fire & ~fire_d_r) | (fire & vsync_pulse & (cooldown_r == {CW{1'b0}}));
`else
    req_s = fire & ~fire_d_r;
`endif
    grant_s = req_s & enable & (cooldown_r == {CW{1'b0}}) & ~(&active_r);
  end

  // Round-robin search for the first free slot starting at rr_ptr
  always_comb begin
    int idx_v;
    idx_v       = 0;
    sel_s       = {PW{1'b0}};
    sel_valid_s = 1'b0;
    for (int i = 0; i < T_NUM; i++) begin
      idx_v = (int'(rr_ptr_r) + i) % T_NUM;
      if (!sel_valid_s && !active_r[idx_v]) begin
        sel_s       = PW'(idx_v);
        sel_valid_s = 1'b1;
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Per-slot next state: a fresh grant beats hit, hit beats frame decrement
  always_comb begin
    for (int k = 0; k < T_NUM; k++) begin
      active_nxt_s[k] = active_r[k];
      life_nxt_s[k]   = life_r[k];
      if (grant_s && sel_valid_s && (sel_s == PW'(k))) begin
        active_nxt_s[k] = 1'b1;
        life_nxt_s[k]   = LW'(LIFE_FRAMES);
      end else if (hit[k] && active_r[k]) begin
        active_nxt_s[k] = 1'b0;
        life_nxt_s[k]   = {LW{1'b0}};
      end else if (vsync_pulse && active_r[k]) begin
        life_nxt_s[k]   = life_r[k] - {{(LW-1){1'b0}}, 1'b1};
        active_nxt_s[k] = (life_r[k] != {{(LW-1){1'b0}}, 1'b1});
      end else begin
        active_nxt_s[k] = active_r[k];
      end
    end
  end

  // Cooldown, pointer, strobe and counter next state
  always_comb begin
    if (grant_s) begin
      cooldown_nxt_s = CW'(COOLDOWN_FRAMES);
    end else if (vsync_pulse && (cooldown_r != {CW{1'b0}})) begin
      cooldown_nxt_s = cooldown_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cooldown_nxt_s = cooldown_r;
    end
    if (grant_s) begin
      launch_nxt_s = {{(T_NUM-1){1'b0}}, 1'b1} << sel_s;
      rr_ptr_nxt_s = (sel_s == PW'(T_NUM - 1)) ? {PW{1'b0}} : sel_s + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      launch_nxt_s = {T_NUM{1'b0}};
      rr_ptr_nxt_s = rr_ptr_r;
    end
    if (grant_s && (shots_r != 16'hFFFF)) begin
      shots_nxt_s = shots_r + 16'd1;
    end else begin
      shots_nxt_s = shots_r;
    end
  end

  // State register; fire_d resets high so a held button cannot fire out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_d_r   <= 1'b1;
      cooldown_r <= {CW{1'b0}};
      rr_ptr_r   <= {PW{1'b0}};
      active_r   <= {T_NUM{1'b0}};
      launch_r   <= {T_NUM{1'b0}};
      all_busy_r <= 1'b0;
      shots_r    <= 16'd0;
      for (int k = 0; k < T_NUM; k++) begin
        life_r[k] <= {LW{1'b0}};
      end
    end else begin
      fire_d_r   <= fire;
      cooldown_r <= cooldown_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      active_r   <= active_nxt_s;
      launch_r   <= launch_nxt_s;
      all_busy_r <= &active_nxt_s;
      shots_r    <= shots_nxt_s;
      for (int k = 0; k < T_NUM; k++) begin
        life_r[k] <= life_nxt_s[k];
      end
    end
  end

  assign launch      = launch_r;
  assign active      = active_r;
  assign all_busy    = all_busy_r;
  assign shots_fired = shots_r;

endmodule
